// File: rtl/muldiv_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Iterative RV32M multiply/divide sequencer placed beside the execute-stage
// ALU. An accepted operation runs DW radix-2 shift-add (multiply) or
// restoring-subtract (divide) iterations on operand magnitudes. The sign is
// fixed up when the result is presented. Divide-by-zero and signed overflow
// skip the iterations and complete on the cycle after accept.
//
// Ports
//   clk_i        core clock, all state on rising edge
//   rst_ni       asynchronous active-low reset
//   valid_i      execute stage holds an M-extension op
//   func3_i      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM,  111 REMU
//   operand_a_i  rs1 value
//   operand_b_i  rs2 value
//   flush_i      pipeline flush, aborts any operation in flight
//   result_o     result, meaningful while valid_o = 1, held afterwards
//   valid_o      one-cycle completion pulse
//   busy_o       sequencer is not idle
//   stall_o      valid_i & ~valid_o, holds the pipeline while the op runs
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [2:0]    func3_i,
    input  logic [DW-1:0] operand_a_i,
    input  logic [DW-1:0] operand_b_i,
    input  logic          flush_i,
    output logic [DW-1:0] result_o,
    output logic          valid_o,
    output logic          busy_o,
    output logic          stall_o
);

    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // Latched operation and iteration state
    logic [2:0]      func3_reg;
    logic            neg_res_reg;   // negate product / quotient at the end
    logic            neg_rem_reg;   // negate remainder at the end
    logic [DW-1:0]   mcand_reg;     // multiplicand or divisor magnitude
    logic [2*DW-1:0] prod_reg;      // {partial sum, remaining multiplier}
    logic [DW-1:0]   quo_reg;       // dividend shifting out, quotient shifting in
    logic [DW-1:0]   rem_reg;       // partial remainder
    logic [CW-1:0]   cnt_reg;
    logic [DW-1:0]   result_reg;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic          req_is_div;
    logic          a_signed, b_signed;
    logic          a_neg, b_neg;
    logic [DW-1:0] a_mag, b_mag;
    logic          div_zero, div_ovf;
    logic          accept;

    always_comb begin
        req_is_div = func3_i[2];
        // Divides: DIV/REM signed, DIVU/REMU unsigned.
        // Multiplies: a signed unless MULHU, b signed only for MUL/MULH.
        a_signed   = req_is_div ? ~func3_i[0] : (func3_i[1:0] != 2'b11);
        b_signed   = req_is_div ? ~func3_i[0] : ~func3_i[1];
        a_neg      = a_signed & operand_a_i[DW-1];
        b_neg      = b_signed & operand_b_i[DW-1];
        a_mag      = a_neg ? -operand_a_i : operand_a_i;
        b_mag      = b_neg ? -operand_b_i : operand_b_i;
        div_zero   = req_is_div & (operand_b_i == '0);
        div_ovf    = req_is_div & ~func3_i[0]
                   & (operand_a_i == {1'b1, {(DW-1){1'b0}}})
                   & (operand_b_i == '1);
        accept     = (state_reg == IDLE) & valid_i & ~flush_i;
    end

    // -------------------------------------------------------------------------
    // Iteration datapath
    // -------------------------------------------------------------------------
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] prod_step;
    logic [DW:0]     rem_shift;
    logic [DW:0]     rem_trial;

    always_comb begin
        // Add multiplicand into the upper half when the multiplier LSB is set,
        // then shift the whole accumulator right, keeping the carry.
        mul_sum   = {1'b0, prod_reg[2*DW-1:DW]}
                  + (prod_reg[0] ? {1'b0, mcand_reg} : {(DW+1){1'b0}});
        prod_step = {mul_sum, prod_reg[DW-1:1]};
        // Restoring step: the remainder stays below the divisor, so the
        // shifted value fits DW+1 bits and the kept value fits DW bits.
        rem_shift = {rem_reg, quo_reg[DW-1]};
        rem_trial = rem_shift - {1'b0, mcand_reg};
    end

    // -------------------------------------------------------------------------
    // Final value select, sign fix-up applied on the full-width magnitudes
    // -------------------------------------------------------------------------
    logic [2*DW-1:0] prod_fix;
    logic [DW-1:0]   quo_fix;
    logic [DW-1:0]   rem_fix;
    logic [DW-1:0]   final_value;

    always_comb begin
        prod_fix = neg_res_reg ? -prod_reg : prod_reg;
        quo_fix  = neg_res_reg ? -quo_reg  : quo_reg;
        rem_fix  = neg_rem_reg ? -rem_reg  : rem_reg;
        case (func3_reg)
            3'b000:                final_value = prod_fix[DW-1:0];
            3'b001, 3'b010, 3'b011: final_value = prod_fix[2*DW-1:DW];
            3'b100, 3'b101:        final_value = quo_fix;
            default:               final_value = rem_fix;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (!req_is_div)             state_next = MUL;
                    else if (div_zero | div_ovf) state_next = DONE;
                    else                         state_next = DIV;
                end
            end
            MUL, DIV: begin
                if (cnt_reg == CW'(1)) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_i) state_next = IDLE;
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            func3_reg   <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            mcand_reg   <= '0;
            prod_reg    <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
        end else if (accept) begin
            func3_reg <= func3_i;
            cnt_reg   <= CW'(DW);
            mcand_reg <= req_is_div ? b_mag : a_mag;
            prod_reg  <= {{DW{1'b0}}, b_mag};
            if (div_zero) begin
                // Results bypass the sign fix-up: all-ones quotient and the
                // raw dividend as remainder.
                neg_res_reg <= 1'b0;
                neg_rem_reg <= 1'b0;
                quo_reg     <= '1;
                rem_reg     <= operand_a_i;
            end else if (div_ovf) begin
                neg_res_reg <= 1'b0;
                neg_rem_reg <= 1'b0;
                quo_reg     <= {1'b1, {(DW-1){1'b0}}};
                rem_reg     <= '0;
            end else begin
                neg_res_reg <= a_neg ^ b_neg;
                neg_rem_reg <= a_neg;
                quo_reg     <= a_mag;
                rem_reg     <= '0;
            end
        end else begin
            case (state_reg)
                MUL: begin
                    prod_reg <= prod_step;
                    cnt_reg  <= cnt_reg - CW'(1);
                end
                DIV: begin
                    if (!rem_trial[DW]) begin
                        rem_reg <= rem_trial[DW-1:0];
                        quo_reg <= {quo_reg[DW-2:0], 1'b1};
                    end else begin
                        rem_reg <= rem_shift[DW-1:0];
                        quo_reg <= {quo_reg[DW-2:0], 1'b0};
                    end
                    cnt_reg <= cnt_reg - CW'(1);
                end
                DONE: begin
                    // Keep the delivered value visible after the pulse.
                    result_reg <= final_value;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign valid_o  = (state_reg == DONE);
    assign busy_o   = (state_reg != IDLE);
    assign result_o = valid_o ? final_value : result_reg;
    assign stall_o  = valid_i & ~valid_o;

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
// Testbench for muldiv_ctrl: directed vectors, scoreboard queue filled by the
// stimulus process and drained by a monitor on every valid_o pulse.
module tb_muldiv_ctrl;

    localparam int DW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          valid_i;
    logic [2:0]    func3_i;
    logic [DW-1:0] operand_a_i;
    logic [DW-1:0] operand_b_i;
    logic          flush_i;
    logic [DW-1:0] result_o;
    logic          valid_o;
    logic          busy_o;
    logic          stall_o;

    muldiv_ctrl #(.DW(DW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .func3_i     (func3_i),
        .operand_a_i (operand_a_i),
        .operand_b_i (operand_b_i),
        .flush_i     (flush_i),
        .result_o    (result_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .stall_o     (stall_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] res;
        int            done_cyc;
        string         name;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every completion pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && valid_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: result=%h at cycle %0d, none expected", result_o, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (result_o !== e.res) begin
                    errors++;
                    $display("FAIL %s result: got %h, want %h", e.name, result_o, e.res);
                end
                checks++;
                if (cyc != e.done_cyc) begin
                    errors++;
                    $display("FAIL %s latency: valid_o at cycle %0d, want %0d", e.name, cyc, e.done_cyc);
                end
                $display("txn %-8s result=%h cycle=%0d", e.name, result_o, cyc);
            end
        end
    end

    task automatic check1(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // Issue one op at a negedge, expect completion lat cycles after issue.
    task automatic do_op(input logic [2:0] f, input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic [DW-1:0] exp_res, input int lat, input string nm);
        exp_t e;
        bit   seen;
        e.res      = exp_res;
        e.done_cyc = cyc + lat;
        e.name     = nm;
        sb_q.push_back(e);
        valid_i     = 1'b1;
        func3_i     = f;
        operand_a_i = x;
        operand_b_i = y;
        #1;
        check1({nm, " stall_c0"}, {31'd0, stall_o}, 32'd1);
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            check1({nm, " stall"}, {31'd0, stall_o}, {31'd0, ~valid_o});
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: no valid_o within 100 cycles", nm);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        valid_i = 1'b0;
        @(negedge clk_i);
        check1({nm, " hold"}, result_o, exp_res);
        check1({nm, " idle"}, {31'd0, busy_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni      = 1'b0;
        valid_i     = 1'b0;
        flush_i     = 1'b0;
        func3_i     = 3'b000;
        operand_a_i = '0;
        operand_b_i = '0;
        repeat (3) @(negedge clk_i);
        check1("reset busy",   {31'd0, busy_o},  32'd0);
        check1("reset valid",  {31'd0, valid_o}, 32'd0);
        check1("reset result", result_o,         32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Multiplies
        do_op(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL");
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH");
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU");
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU");

        // Divides
        do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV");
        do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM");
        do_op(3'b101, 32'd100,       32'd7, 32'd14,        33, "DIVU");
        do_op(3'b111, 32'd100,       32'd7, 32'd2,         33, "REMU");

        // Early-out cases
        do_op(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "DIVU/0");
        do_op(3'b110, 32'd5,         32'd0,         32'd5,         1, "REM/0");
        do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIVovf");
        do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "REMovf");

        // flush_i together with valid_i in IDLE: request must not be taken
        valid_i = 1'b1; flush_i = 1'b1; func3_i = 3'b000;
        operand_a_i = 32'd9; operand_b_i = 32'd9;
        @(negedge clk_i);
        check1("flush_idle busy", {31'd0, busy_o}, 32'd0);
        valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk_i);

        // Flush mid-divide in cycle 10, new MUL in cycle 11
        valid_i = 1'b1; func3_i = 3'b100;
        operand_a_i = 32'd50; operand_b_i = 32'd3;
        repeat (10) @(negedge clk_i);
        check1("pre_flush busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1; valid_i = 1'b0;
        @(negedge clk_i);
        flush_i = 1'b0;
        check1("flush busy", {31'd0, busy_o}, 32'd0);
        do_op(3'b000, 32'd3, 32'd4, 32'd12, 33, "MUL_aft");

        // Asynchronous reset in the middle of a multiply
        valid_i = 1'b1; func3_i = 3'b000;
        operand_a_i = 32'd5; operand_b_i = 32'd6;
        repeat (5) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        check1("arst busy",   {31'd0, busy_o},  32'd0);
        check1("arst valid",  {31'd0, valid_o}, 32'd0);
        check1("arst result", result_o,         32'd0);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        do_op(3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1,         33, "MULHU2");
        do_op(3'b000, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 33, "MUL2");

        repeat (3) @(negedge clk_i);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Iterative sequencer for the RV32M multiply/divide instructions, sitting beside the execute-stage ALU. It accepts one operation per issue from the decode/execute path, runs DW shift-add or restoring-subtract iterations, and returns the result. While an operation is outstanding it holds a stall to the pipeline. Division by zero and signed overflow are handled as early-out cases without iterating.

Parameters:
DW, 32, operand/result width; power of two, >= 8.

Ports:
clk_i  input  1  core clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  request: execute stage holds an M-extension op (opcode 0x33, func7 = 0x01)
func3_i  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
operand_a_i  input  DW  rs1 value
operand_b_i  input  DW  rs2 value
flush_i  input  1  pipeline flush; aborts any operation
result_o  output  DW  result; meaningful only when valid_o = 1
valid_o  output  1  one-cycle completion pulse
busy_o  output  1  state != IDLE
stall_o  output  1  combinational: valid_i & ~valid_o

Behaviour:
- Reset (async, rst_ni = 0): state = IDLE; result_o = 0; valid_o = 0; busy_o = 0; counter and accumulators = 0. Deassertion takes effect on the next clock edge.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, valid_i = 1, flush_i = 0: latch the op, operand magnitudes and sign flags.
  - func3[2] = 0: go to MUL.
  - func3[2] = 1 and operand_b_i = 0: go to DONE.
  - Signed DIV/REM with a = 2^(DW-1) and b = all-ones: go to DONE.
  - All other divides: go to DIV.
- Counter: loaded with DW on accept; decrements once per MUL/DIV cycle. When the counter reaches 1, the next state is DONE. Exactly DW iteration cycles.
- MUL: radix-2 shift-add on a 2*DW-bit accumulator using unsigned magnitudes.
  - Sign handling: MUL and MULH treat both operands as signed; MULHSU treats only a as signed; MULHU treats both as unsigned.
  - Final product is negated if the operand signs differ (applicable signs only).
  - MUL returns the low DW bits; the MULH variants return the high DW bits.
- DIV: restoring division of magnitudes.
  - Quotient is negated if the signs differ (DIV only).
  - Remainder takes the sign of the dividend (REM only).
  - DIVU/REMU are unsigned.
- Early-out results:
  - Divide by zero: quotient = all-ones; remainder = operand_a_i.
  - Signed overflow: quotient = 2^(DW-1); remainder = 0.
- DONE: valid_o = 1 and result_o = final value for exactly one cycle; then go to IDLE unconditionally. result_o holds its value after valid_o falls.
- Latency:
  - Iterative ops: valid_o is high in the (DW+1)th cycle after the accept edge (cycle 33 for DW = 32).
  - Early-out ops: valid_o is high in cycle 1 after accept.
- Handshake:
  - The requester holds valid_i and operands stable until valid_o.
  - valid_i in MUL/DIV is ignored; operands are not re-sampled.
  - On valid_o the pipeline advances. The DONE -> IDLE transition guarantees the same instruction is not re-accepted; a new request is accepted in IDLE on the following cycle.
- Flush:
  - flush_i in any state: next state IDLE; valid_o is not asserted for the aborted op.
  - flush_i in DONE suppresses nothing; the pulse in that cycle still occurs, but the consumer discards it.
  - flush_i together with valid_i in IDLE: the request is not accepted.
- Reset mid-operation: the op is abandoned and no valid_o is produced.
- All internal arithmetic uses 2*DW-bit or DW+1-bit widths; no truncation before the final select.

Test Plan:
- MUL a = 7, b = 0xFFFFFFFD (-3) -> valid_o in cycle 33, result 0xFFFFFFEB; stall_o high in cycles 0-32, low in cycle 33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2; each with latency 33.
- DIVU 5 / 0 -> 0xFFFFFFFF in cycle 1; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, both in cycle 1.
- Start DIV, assert flush_i in cycle 10 -> busy_o = 0 in cycle 11, no valid_o; a new MUL 3 x 4 in cycle 11 -> 12 in cycle 44.
- Drop rst_ni asynchronously mid-MUL -> busy_o, valid_o and result_o go to 0 immediately; after release, the next op completes normally.
